// File: rtl/counter_scheduler.sv
// Round-robin sharing of one interval counter: grants one requester a slot of dur cycles, then pulses done.
// Grant appears the cycle after req is seen in IDLE; 2-cycle turnaround (1 after abort); req/dur ignored while busy.
module counter_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    dur,
  input  logic                     abort,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [WIDTH-1:0]         count,
  output logic [$clog2(NREQ)-1:0]  owner
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [NREQ-1:0]  gnt_n, done_n;
  logic [WIDTH-1:0] count_n, limit, limit_n;
  logic [IW-1:0]    owner_n, last, last_n, pick, cand;
  logic             found;
  logic [WIDTH-1:0] dur_a [NREQ];

  always_comb begin : dur_unpack
    for (int i = 0; i < NREQ; i++) dur_a[i] = dur[i*WIDTH +: WIDTH];
  end

  // Search starts just after the previous grantee so every waiting requester is served in turn.
  always_comb begin : rr_pick
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin : fsm_next
    state_n = state;
    gnt_n   = gnt;
    done_n  = '0;
    count_n = count;
    owner_n = owner;
    last_n  = last;
    limit_n = limit;
    case (state)
      IDLE: begin
        if (found) begin
          limit_n = dur_a[pick];
          last_n  = pick;
          owner_n = pick;
          gnt_n   = NREQ'(1) << pick;
          count_n = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          gnt_n   = '0;
          count_n = '0;
          state_n = IDLE;
        // limit of 0 wraps to all-ones here, giving the full 2^WIDTH-cycle slot.
        end else if (count == limit - WIDTH'(1)) begin
          gnt_n         = '0;
          done_n[owner] = 1'b1;
          count_n       = '0;
          state_n       = DONE;
        end else begin
          count_n = count + WIDTH'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      count <= '0;
      owner <= '0;
      last  <= IW'(NREQ - 1);
      limit <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      done  <= done_n;
      count <= count_n;
      owner <= owner_n;
      last  <= last_n;
      limit <= limit_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/counter_scheduler.md
# counter_scheduler

Round-robin scheduler that shares one WIDTH-bit interval counter among NREQ requesters. Each requester asks for a timed slot of programmable length. The block grants one requester at a time, runs the counter for exactly that many cycles, then pulses a per-requester done. It sits in front of the free-running counter datapath and turns it into a shared, sequenced timing resource.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, counter width; slot length range 1..2^WIDTH cycles
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-low (0 = reset, sampled on posedge clk)
- req  input  NREQ  per-requester slot request level; sampled only in IDLE
- dur  input  NREQ*WIDTH  slot length; requester i uses dur[i*WIDTH +: WIDTH]; 0 encodes 2^WIDTH
- abort  input  1  terminate current slot early; honoured only in RUN
- gnt  output  NREQ  one-hot grant; all-zero when no slot is running
- done  output  NREQ  one-cycle pulse on bit i when requester i's slot completes normally
- busy  output  1  high whenever state is not IDLE
- count  output  WIDTH  elapsed cycles in current slot
- owner  output  $clog2(NREQ)  index of the current or most recent grantee

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset (reset == 0 at posedge):
  - state IDLE, gnt 0, done 0, busy 0, count 0, owner 0.
  - RR pointer last = NREQ-1, so requester 0 has first priority.
  - Reset overrides abort and req.
- IDLE:
  - If req != 0, pick the first asserted bit searching last+1, last+2, ... modulo NREQ. Call it i.
  - Capture limit = dur slice i; set last = i and owner = i.
  - Set gnt = one-hot(i), count = 0, and go to RUN.
  - If req == 0, remain in IDLE.
- RUN:
  - abort == 1: go to IDLE with gnt 0, count 0, and no done pulse. last stays at i, so the next grant goes to a different requester when one is waiting.
  - Else, if count == limit - 1 (WIDTH-bit modular, so limit 0 compares against 2^WIDTH-1): go to DONE with gnt 0, done[i] = 1, count 0.
  - Else: count <= count + 1.
  - req changes and dur changes during RUN are ignored; limit is latched.
- DONE: done cleared, unconditionally go to IDLE.
- busy = (state != IDLE).
- owner holds its value after the slot ends until the next grant.
- count never wraps within a slot; the maximum value is 2^WIDTH-1, reached only for limit 0.

## Timing
- Grant latency: req sampled high in IDLE at edge E gives gnt valid after E. The capturing edge itself is not in RUN.
- A slot of length d: gnt is high for exactly d cycles (16 for d = 0 with WIDTH = 4). count shows 0, 1, ..., d-1 during those cycles.
- done[i] is high for exactly the one cycle immediately after the last gnt cycle (the DONE cycle).
- Turnaround: back-to-back grants are separated by exactly 2 cycles (DONE, IDLE) after normal completion. After abort the gap is 1 cycle (IDLE).
- abort at edge E: gnt is low after E.
- Reset low at edge E in any state: all outputs are at reset values after E, with no done pulse.
- req, dur and abort need only be stable around posedge clk. There is no combinational input-to-output path.

## Test plan
- Single slot: reset, then req = 0001, dur0 = 3 → gnt = 0001 for 3 cycles with count 0, 1, 2; next cycle done = 0001 and gnt = 0; then busy falls.
- Round-robin: req = 1111 held, all dur = 1 → grants in order 0, 1, 2, 3, 0. Each gnt lasts 1 cycle; done bits follow the same order with a 2-cycle gap between grants.
- Wrap boundary: dur2 = 0, req = 0100 → gnt = 0100 for 16 cycles with count 0..15; done[2] pulses once and count returns to 0.
- Abort: dur1 = 8, abort pulsed while count = 2 → gnt = 0 on the next cycle with no done. With req = 0011 held, the next grant is requester 0 (after 1 idle cycle), not 1.
- Reset mid-slot: dur0 = 10, reset driven low while count = 5 → the next cycle has all outputs 0 and no done. After release, with req = 1010, requester 1 is granted first.
- Request drop: req0 deasserted and dur0 changed to 1 during a dur0 = 6 slot → the grant still lasts 6 cycles and done[0] still pulses.
